// File: rtl/spike_argmax_readout.sv
// spike_argmax_readout
//   Output-layer classification readout. Counts spikes per class over a
//   programmable window, scans the counts one class per cycle to find the
//   argmax (lowest index wins on a tie) and presents class, winning count and
//   a tie flag alongside a one-cycle valid pulse.

module spike_argmax_readout #(
  parameter  int NUM_CLASSES = 10,
  parameter  int COUNT_W     = 8,
  parameter  int WINDOW_W    = 8,
  localparam int CLASS_W     = $clog2(NUM_CLASSES)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [WINDOW_W-1:0]    window_len_i,
  input  logic [NUM_CLASSES-1:0] spike_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic [CLASS_W-1:0]     class_o,
  output logic [COUNT_W-1:0]     max_count_o,
  output logic                   tie_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [CLASS_W-1:0] LAST_IDX  = CLASS_W'(NUM_CLASSES - 1);

  state_t               state_r, state_nxt_s;
  logic                 accept_s;
  logic                 scan_last_s;
  logic [COUNT_W-1:0]   count_r [NUM_CLASSES];
  logic [WINDOW_W-1:0]  win_r;
  logic [CLASS_W-1:0]   scan_idx_r;
  logic [COUNT_W-1:0]   cand_s;
  logic [COUNT_W-1:0]   best_r, best_nxt_s;
  logic [CLASS_W-1:0]   best_idx_r, best_idx_nxt_s;
  logic                 tie_r, tie_nxt_s;
  logic                 busy_r, valid_r, tie_out_r;
  logic [CLASS_W-1:0]   class_r;
  logic [COUNT_W-1:0]   max_r;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a start is only honoured while idle.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    scan_last_s = (scan_idx_r == LAST_IDX);
    case (state_r)
      IDLE: begin
        if (start_i) begin
          accept_s = 1'b1;
          if (window_len_i != WINDOW_W'(0)) begin
            state_nxt_s = ACCUM;
          end else begin
            state_nxt_s = SCAN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        if (win_r == WINDOW_W'(1)) begin
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      SCAN: begin
        if (scan_last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Per-class saturating spike counters, cleared when a window is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CLASSES; i++) count_r[i] <= COUNT_W'(0);
    end else begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (accept_s) begin
          count_r[i] <= COUNT_W'(0);
        end else if (state_r == ACCUM && spike_i[i] && count_r[i] != COUNT_MAX) begin
          count_r[i] <= count_r[i] + COUNT_W'(1);
        end
      end
    end
  end

  // Window down-counter; leaves ACCUM at 1 so it never wraps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_r <= WINDOW_W'(0);
    end else if (accept_s) begin
      win_r <= window_len_i;
    end else if (state_r == ACCUM) begin
      win_r <= win_r - WINDOW_W'(1);
    end
  end

  // One argmax step for the class currently addressed by the scan index.
  always_comb begin
    cand_s         = count_r[scan_idx_r];
    best_nxt_s     = best_r;
    best_idx_nxt_s = best_idx_r;
    tie_nxt_s      = tie_r;
    if (scan_idx_r == CLASS_W'(0)) begin
      best_nxt_s     = cand_s;
      best_idx_nxt_s = CLASS_W'(0);
      tie_nxt_s      = 1'b0;
    end else if (cand_s > best_r) begin
      best_nxt_s     = cand_s;
      best_idx_nxt_s = scan_idx_r;
      tie_nxt_s      = 1'b0;
    end else if (cand_s == best_r) begin
      tie_nxt_s      = 1'b1;
    end else begin
      tie_nxt_s      = tie_r;
    end
  end

  // Scan index and running best, advanced once per SCAN cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scan_idx_r <= CLASS_W'(0);
      best_r     <= COUNT_W'(0);
      best_idx_r <= CLASS_W'(0);
      tie_r      <= 1'b0;
    end else if (accept_s) begin
      scan_idx_r <= CLASS_W'(0);
    end else if (state_r == SCAN) begin
      scan_idx_r <= scan_last_s ? CLASS_W'(0) : scan_idx_r + CLASS_W'(1);
      best_r     <= best_nxt_s;
      best_idx_r <= best_idx_nxt_s;
      tie_r      <= tie_nxt_s;
    end
  end

  // Registered outputs; results load on entry to DONE so they appear with valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      class_r   <= CLASS_W'(0);
      max_r     <= COUNT_W'(0);
      tie_out_r <= 1'b0;
    end else begin
      busy_r  <= (state_nxt_s != IDLE);
      valid_r <= (state_r == SCAN) && scan_last_s;
      if ((state_r == SCAN) && scan_last_s) begin
        class_r   <= best_idx_nxt_s;
        max_r     <= best_nxt_s;
        tie_out_r <= tie_nxt_s;
      end
    end
  end

  assign busy_o      = busy_r;
  assign valid_o     = valid_r;
  assign class_o     = class_r;
  assign max_count_o = max_r;
  assign tie_o       = tie_out_r;

endmodule
